// File: rtl/dma_mem_port.sv
// Byte-wide memory port for a nibble-serial DMA: packs nibbles into memory writes
// (cpu_to_mem) or unpacks memory reads into nibbles (mem_to_cpu), low nibble first.
module dma_mem_port #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mode,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [3:0]        nib_in,
    input  logic              nib_in_valid,
    output logic              nib_in_enable,
    output logic [3:0]        nib_out,
    output logic              nib_out_valid,
    input  logic              nib_out_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count,
    output logic [3:0]        state_dbg
);

    // Handshake: a nibble moves on a posedge where valid and enable are both high;
    // the source holds its nibble until that edge, and nothing else moves data.

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_LO   = 4'd1,
        WR_HI   = 4'd2,
        WR_MEM  = 4'd3,
        RD_REQ  = 4'd4,
        RD_WAIT = 4'd5,
        RD_LO   = 4'd6,
        RD_HI   = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                mode_r;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   len_r;
    logic [ADDR_W-1:0]   count_r;
    logic [3:0]          lo_nib;
    logic [3:0]          hi_nib;
    logic [7:0]          rd_byte;
    logic                start_ok;
    logic                count_inc;
    logic [ADDR_W-1:0]   count_plus1;
    logic [ADDR_W-1:0]   cur_addr;

    // Both sums wrap naturally at 2^ADDR_W.
    assign count_plus1 = count_r + 1'b1;
    assign cur_addr    = base_r + count_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            mode_r  <= 1'b0;
            base_r  <= '0;
            len_r   <= '0;
            count_r <= '0;
            lo_nib  <= 4'h0;
            hi_nib  <= 4'h0;
            rd_byte <= 8'h00;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                mode_r  <= mode;
                base_r  <= base_addr;
                len_r   <= len;
                count_r <= '0;
            end else if (count_inc) begin
                count_r <= count_plus1;
            end
            if (state == WR_LO && nib_in_valid) begin
                lo_nib <= nib_in;
            end
            if (state == WR_HI && nib_in_valid) begin
                hi_nib <= nib_in;
            end
            if (state == RD_WAIT) begin
                rd_byte <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        start_ok      = 1'b0;
        count_inc     = 1'b0;
        nib_in_enable = 1'b0;
        nib_out_valid = 1'b0;
        nib_out       = 4'h0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = 8'h00;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_ok = 1'b1;
                    if (len == '0) begin
                        state_nx = DONE;
                    end else if (mode) begin
                        state_nx = WR_LO;
                    end else begin
                        state_nx = RD_REQ;
                    end
                end
            end
            WR_LO: begin
                nib_in_enable = 1'b1;
                if (nib_in_valid) state_nx = WR_HI;
            end
            WR_HI: begin
                nib_in_enable = 1'b1;
                if (nib_in_valid) state_nx = WR_MEM;
            end
            WR_MEM: begin
                // A cancelled cycle must not touch memory or the count.
                mem_we    = !abort;
                count_inc = !abort;
                mem_wdata = {hi_nib, lo_nib};
                mem_addr  = cur_addr;
                state_nx  = (count_plus1 == len_r) ? DONE : WR_LO;
            end
            RD_REQ: begin
                mem_re   = !abort;
                mem_addr = cur_addr;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                state_nx = RD_LO;
            end
            RD_LO: begin
                nib_out_valid = 1'b1;
                nib_out       = rd_byte[3:0];
                if (nib_out_enable) state_nx = RD_HI;
            end
            RD_HI: begin
                nib_out_valid = 1'b1;
                nib_out       = rd_byte[7:4];
                if (nib_out_enable) begin
                    count_inc = !abort;
                    state_nx  = (count_plus1 == len_r) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort && state != IDLE && state != DONE) begin
            state_nx = IDLE;
        end
    end

    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);
    assign byte_count = count_r;
    assign state_dbg  = state;

endmodule
